mem_stage: RTL and testbench

Memory-access stage of the five-stage pipeline, sitting between the EX/MEM pipeline register and the MEM_WB register. It owns the word-addressed data memory and services loads and stores with a configurable access latency, stalling upstream stages while an access is in flight. It presents ALU result, load data, destination register and write-back controls to MEM_WB one cycle after an instruction completes.

---
 rtl/mem_stage_pkg.sv | 25 ++
 rtl/dmem_array.sv | 35 +++
 rtl/mem_stage.sv | 135 +++++++++++++
 tb/tb_mem_stage.sv | 201 ++++++++++++++++++++
 4 files changed

// File: rtl/mem_stage_pkg.sv
// Shared types and widths for the memory-access pipeline stage.
// No logic; imported by mem_stage and dmem_array.
package mem_stage_pkg;

    localparam int CNT_W      = 4;
    localparam int REG_ADDR_W = 5;
    localparam int DATA_W     = 32;

    typedef enum logic {
        IDLE = 1'b0,
        BUSY = 1'b1
    } state_t;

    // Request fields held while a multi-cycle access is in flight.
    typedef struct packed {
        logic                  mem_read;
        logic                  mem_write;
        logic [DATA_W-1:0]     addr;
        logic [DATA_W-1:0]     wdata;
        logic [REG_ADDR_W-1:0] rd_addr;
        logic                  mem_to_reg;
        logic                  reg_write;
    } req_t;

endpackage

// File: rtl/dmem_array.sv
// Single-port word RAM, read-before-write; rdata registered, zero when no read is requested.
// Latency: 1 edge. Backpressure: none, caller decides when to enable.
// Contents are not reset; only the read register is.
module dmem_array
    import mem_stage_pkg::*;
#(
    parameter int DEPTH = 256,
    parameter int IDX_W = $clog2(DEPTH)
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              re,
    input  logic              we,
    input  logic [IDX_W-1:0]  addr,
    input  logic [DATA_W-1:0] wdata,
    output logic [DATA_W-1:0] rdata
);

    logic [DATA_W-1:0] mem [DEPTH];

    always_ff @(posedge clk_i) begin
        if (we) begin
            mem[addr] <= wdata;
        end
    end

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            rdata <= '0;
        end else begin
            rdata <= re ? mem[addr] : '0;
        end
    end

endmodule

// File: rtl/mem_stage.sv
// Memory stage: data memory access with LATENCY wait cycles, results registered toward MEM_WB.
// Latency: 1 cycle for non-memory ops, LATENCY+1 for loads/stores. Backpressure: stall_o holds upstream.
// Optional misaligned-access trap via MEM_STAGE_MISALIGN_TRAP_EN (adds misalign_o).
module mem_stage
    import mem_stage_pkg::*;
#(
    parameter int DEPTH   = 256,
    parameter int LATENCY = 2
) (
    input  logic                  clk_i,
    input  logic                  rst_i,
    input  logic                  valid_i,
    input  logic                  flush_i,
    input  logic                  mem_read_i,
    input  logic                  mem_write_i,
    input  logic [DATA_W-1:0]     addr_i,
    input  logic [DATA_W-1:0]     wdata_i,
    input  logic [REG_ADDR_W-1:0] rd_addr_i,
    input  logic                  mem_to_reg_i,
    input  logic                  reg_write_i,
    output logic                  stall_o,
    output logic                  valid_o,
    output logic [DATA_W-1:0]     alu_res_o,
    output logic [DATA_W-1:0]     read_data_o,
    output logic [REG_ADDR_W-1:0] rd_addr_o,
    output logic                  mem_to_reg_o,
    output logic                  reg_write_o
`ifdef MEM_STAGE_MISALIGN_TRAP_EN
    ,
    output logic                  misalign_o
`endif
);

    localparam int IDX_W = $clog2(DEPTH);
    localparam logic [CNT_W-1:0] CNT_INIT = CNT_W'((LATENCY == 0) ? 0 : LATENCY - 1);
    localparam logic HAS_WAIT = (LATENCY != 0);

    state_t            state;
    logic [CNT_W-1:0]  cnt;
    req_t              cap;
    req_t              req;
    req_t              cur;
    logic              busy;
    logic              mis;
    logic              mem_op;
    logic              complete;

`ifdef MEM_STAGE_MISALIGN_TRAP_EN
    assign mis = valid_i & (mem_read_i | mem_write_i) & (addr_i[1:0] != 2'b00);
`else
    assign mis = 1'b0;
`endif

    assign req = '{mem_read:   mem_read_i,
                   mem_write:  mem_write_i,
                   addr:       addr_i,
                   wdata:      wdata_i,
                   rd_addr:    rd_addr_i,
                   mem_to_reg: mem_to_reg_i,
                   reg_write:  reg_write_i};

    assign busy     = (state == BUSY);
    assign cur      = busy ? cap : req;
    assign mem_op   = valid_i & (mem_read_i | mem_write_i) & ~mis;
    // Stall never depends on data; reset drops it immediately.
    assign stall_o  = rst_i & ~flush_i & (busy ? (cnt != '0) : (mem_op & HAS_WAIT));
    assign complete = ~flush_i & (busy ? (cnt == '0) : (mem_op & ~HAS_WAIT));

    dmem_array #(
        .DEPTH (DEPTH)
    ) u_dmem (
        .clk_i (clk_i),
        .rst_i (rst_i),
        .re    (complete & cur.mem_read),
        .we    (complete & cur.mem_write),
        .addr  (cur.addr[IDX_W+1:2]),
        .wdata (cur.wdata),
        .rdata (read_data_o)
    );

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            state        <= IDLE;
            cnt          <= '0;
            cap          <= '0;
            valid_o      <= 1'b0;
            alu_res_o    <= '0;
            rd_addr_o    <= '0;
            mem_to_reg_o <= 1'b0;
            reg_write_o  <= 1'b0;
        end else if (flush_i) begin
            state       <= IDLE;
            cnt         <= '0;
            valid_o     <= 1'b0;
            reg_write_o <= 1'b0;
        end else if (busy) begin
            if (cnt != '0) begin
                cnt <= cnt - 1'b1;
            end else begin
                state        <= IDLE;
                valid_o      <= 1'b1;
                alu_res_o    <= cap.addr;
                rd_addr_o    <= cap.rd_addr;
                mem_to_reg_o <= cap.mem_to_reg;
                reg_write_o  <= cap.reg_write;
            end
        end else if (mem_op && HAS_WAIT) begin
            // Accept the request and emit a bubble until the access completes.
            state       <= BUSY;
            cnt         <= CNT_INIT;
            cap         <= req;
            valid_o     <= 1'b0;
            reg_write_o <= 1'b0;
        end else begin
            valid_o      <= valid_i;
            alu_res_o    <= addr_i;
            rd_addr_o    <= rd_addr_i;
            mem_to_reg_o <= mem_to_reg_i;
            reg_write_o  <= valid_i & reg_write_i & ~mis;
        end
    end

`ifdef MEM_STAGE_MISALIGN_TRAP_EN
    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            misalign_o <= 1'b0;
        end else if (flush_i || busy) begin
            misalign_o <= 1'b0;
        end else begin
            misalign_o <= mis;
        end
    end
`endif

endmodule

// File: tb/tb_mem_stage.sv
// Scoreboard bench for mem_stage (DEPTH=256, LATENCY=2): expected results queued at issue,
// compared on the falling edge whenever valid_o is high.
module tb_mem_stage;

    logic        clk_i = 1'b0;
    logic        rst_i;
    logic        valid_i, flush_i, mem_read_i, mem_write_i;
    logic [31:0] addr_i, wdata_i;
    logic [4:0]  rd_addr_i;
    logic        mem_to_reg_i, reg_write_i;
    logic        stall_o, valid_o;
    logic [31:0] alu_res_o, read_data_o;
    logic [4:0]  rd_addr_o;
    logic        mem_to_reg_o, reg_write_o;
`ifdef MEM_STAGE_MISALIGN_TRAP_EN
    logic        misalign_o;
`endif

    typedef struct {
        logic [31:0] alu;
        logic [31:0] rdata;
        logic        chk_rd;
        logic [4:0]  rd;
        logic        mtr;
        logic        rw;
        logic        mis;
    } exp_t;

    exp_t q[$];
    int   n_chk = 0;
    int   n_err = 0;

    mem_stage #(.DEPTH(256), .LATENCY(2)) dut (
        .clk_i        (clk_i),
        .rst_i        (rst_i),
        .valid_i      (valid_i),
        .flush_i      (flush_i),
        .mem_read_i   (mem_read_i),
        .mem_write_i  (mem_write_i),
        .addr_i       (addr_i),
        .wdata_i      (wdata_i),
        .rd_addr_i    (rd_addr_i),
        .mem_to_reg_i (mem_to_reg_i),
        .reg_write_i  (reg_write_i),
        .stall_o      (stall_o),
        .valid_o      (valid_o),
        .alu_res_o    (alu_res_o),
        .read_data_o  (read_data_o),
        .rd_addr_o    (rd_addr_o),
        .mem_to_reg_o (mem_to_reg_o),
        .reg_write_o  (reg_write_o)
`ifdef MEM_STAGE_MISALIGN_TRAP_EN
        ,
        .misalign_o   (misalign_o)
`endif
    );

    always #5 clk_i = ~clk_i;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    always @(negedge clk_i) begin
        if (rst_i === 1'b1 && valid_o === 1'b1) begin
            if (q.size() == 0) begin
                chk("sb_unexpected_valid", 32'd1, 32'd0);
            end else begin
                exp_t e;
                e = q.pop_front();
                chk("sb_alu_res", alu_res_o, e.alu);
                chk("sb_rd_addr", 32'(rd_addr_o), 32'(e.rd));
                chk("sb_mem_to_reg", 32'(mem_to_reg_o), 32'(e.mtr));
                chk("sb_reg_write", 32'(reg_write_o), 32'(e.rw));
                if (e.chk_rd) chk("sb_read_data", read_data_o, e.rdata);
`ifdef MEM_STAGE_MISALIGN_TRAP_EN
                chk("sb_misalign", 32'(misalign_o), 32'(e.mis));
`endif
            end
        end
    end

    task automatic drive(input logic rd, input logic wr, input logic [31:0] a, input logic [31:0] wd,
                         input logic [4:0] rda, input logic mtr, input logic rw);
        valid_i = 1'b1; mem_read_i = rd; mem_write_i = wr; addr_i = a; wdata_i = wd;
        rd_addr_i = rda; mem_to_reg_i = mtr; reg_write_i = rw;
    endtask

    task automatic idle_inputs();
        valid_i = 1'b0; mem_read_i = 1'b0; mem_write_i = 1'b0; flush_i = 1'b0;
    endtask

    // Present one instruction, count stall cycles, expect completion on the following edge.
    task automatic issue(input logic rd, input logic wr, input logic [31:0] a, input logic [31:0] wd,
                         input logic [4:0] rda, input logic mtr, input logic rw,
                         input int exp_stall, input logic [31:0] exp_rdata, input logic exp_mis);
        exp_t e;
        int   n;
        drive(rd, wr, a, wd, rda, mtr, rw);
        e = '{alu: a, rdata: exp_rdata, chk_rd: rd & ~exp_mis, rd: rda, mtr: mtr,
              rw: rw & ~exp_mis, mis: exp_mis};
        q.push_back(e);
        n = 0;
        #1;
        while (stall_o === 1'b1 && n < 40) begin
            n++;
            @(posedge clk_i); #1;
            if (stall_o === 1'b1) chk("bubble_valid", 32'(valid_o), 32'd0);
        end
        chk("stall_cycles", n, exp_stall);
        @(posedge clk_i); #1;
        chk("done_valid", 32'(valid_o), 32'd1);
        idle_inputs();
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    initial begin
        rst_i = 1'b0;
        idle_inputs();
        addr_i = '0; wdata_i = '0; rd_addr_i = '0; mem_to_reg_i = 1'b0; reg_write_i = 1'b0;
        repeat (2) @(posedge clk_i);
        #1;
        chk("rst_valid", 32'(valid_o), 32'd0);
        chk("rst_stall", 32'(stall_o), 32'd0);
        chk("rst_alu_res", alu_res_o, 32'd0);
        chk("rst_read_data", read_data_o, 32'd0);
        chk("rst_reg_write", 32'(reg_write_o), 32'd0);
        rst_i = 1'b1;
        @(posedge clk_i); #1;

        // Store then load, back to back.
        issue(1'b0, 1'b1, 32'h10, 32'hDEADBEEF, 5'd0, 1'b0, 1'b0, 2, 32'h0, 1'b0);
        issue(1'b1, 1'b0, 32'h10, 32'h0, 5'd3, 1'b1, 1'b1, 2, 32'hDEADBEEF, 1'b0);
        // ALU pass-through.
        issue(1'b0, 1'b0, 32'h1234, 32'h0, 5'd5, 1'b0, 1'b1, 0, 32'h0, 1'b0);
        // Address wrap modulo DEPTH words.
        issue(1'b0, 1'b1, 32'h400, 32'h55, 5'd0, 1'b0, 1'b0, 2, 32'h0, 1'b0);
        issue(1'b1, 1'b0, 32'h0, 32'h0, 5'd9, 1'b1, 1'b1, 2, 32'h55, 1'b0);
        // Read+write returns the pre-write word.
        issue(1'b0, 1'b1, 32'h40, 32'h77, 5'd0, 1'b0, 1'b0, 2, 32'h0, 1'b0);
        issue(1'b1, 1'b1, 32'h40, 32'h99, 5'd4, 1'b1, 1'b1, 2, 32'h77, 1'b0);
        issue(1'b1, 1'b0, 32'h40, 32'h0, 5'd6, 1'b1, 1'b1, 2, 32'h99, 1'b0);

        // Flush in the second stall cycle kills the store.
        issue(1'b0, 1'b1, 32'h20, 32'hAAAA, 5'd0, 1'b0, 1'b0, 2, 32'h0, 1'b0);
        issue(1'b0, 1'b0, 32'h88, 32'h0, 5'd7, 1'b0, 1'b1, 0, 32'h0, 1'b0);
        drive(1'b0, 1'b1, 32'h20, 32'hBBBB, 5'd0, 1'b0, 1'b1);
        #1 chk("flush_stall_1", 32'(stall_o), 32'd1);
        @(posedge clk_i); #1;
        chk("flush_stall_2", 32'(stall_o), 32'd1);
        flush_i = 1'b1;
        #1 chk("flush_stall_kill", 32'(stall_o), 32'd0);
        @(posedge clk_i); #1;
        idle_inputs();
        chk("flush_valid", 32'(valid_o), 32'd0);
        chk("flush_reg_write", 32'(reg_write_o), 32'd0);
        #1 chk("flush_idle_stall", 32'(stall_o), 32'd0);
        @(posedge clk_i); #1;
        issue(1'b1, 1'b0, 32'h20, 32'h0, 5'd8, 1'b1, 1'b1, 2, 32'hAAAA, 1'b0);

        // Reset during BUSY discards the pending store.
        issue(1'b0, 1'b1, 32'h30, 32'h2222, 5'd0, 1'b0, 1'b0, 2, 32'h0, 1'b0);
        issue(1'b1, 1'b0, 32'h30, 32'h0, 5'd11, 1'b1, 1'b1, 2, 32'h2222, 1'b0);
        drive(1'b0, 1'b1, 32'h30, 32'h1111, 5'd0, 1'b0, 1'b0);
        @(posedge clk_i); #1;
        rst_i = 1'b0;
        #1;
        chk("mid_rst_stall", 32'(stall_o), 32'd0);
        chk("mid_rst_valid", 32'(valid_o), 32'd0);
        chk("mid_rst_alu_res", alu_res_o, 32'd0);
        chk("mid_rst_read_data", read_data_o, 32'd0);
        chk("mid_rst_rd_addr", 32'(rd_addr_o), 32'd0);
        chk("mid_rst_mem_to_reg", 32'(mem_to_reg_o), 32'd0);
        idle_inputs();
        @(posedge clk_i); #1;
        rst_i = 1'b1;
        @(posedge clk_i); #1;
        issue(1'b1, 1'b0, 32'h30, 32'h0, 5'd12, 1'b1, 1'b1, 2, 32'h2222, 1'b0);

`ifdef MEM_STAGE_MISALIGN_TRAP_EN
        issue(1'b1, 1'b0, 32'h13, 32'h0, 5'd13, 1'b1, 1'b1, 0, 32'h0, 1'b1);
        issue(1'b1, 1'b0, 32'h10, 32'h0, 5'd14, 1'b1, 1'b1, 2, 32'hDEADBEEF, 1'b0);
`endif

        repeat (3) @(posedge clk_i);
        #1;
        chk("sb_drained", q.size(), 32'd0);
        $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
        $finish;
    end

endmodule
